fetch_sequencer: RTL

Parametrised program-counter sequencer, successor to the current fixed 8-bit fetch unit. It adds configurable PC width, branch offset width and scaling, and lookup-table absolute jumps. It also adds a call/return stack, stall, a sticky halted state and fault reporting. Sits at the front of the single-cycle core and drives the instruction-memory address every cycle.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_sequencer_return_stack.sv | 52 +++++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared op/state encodings and defaults for the fetch sequencer
package fetch_pkg;

    typedef enum logic [2:0] {
        OP_INC      = 3'b000,
        OP_BR_REL   = 3'b001,
        OP_JMP_LUT  = 3'b010,
        OP_CALL_LUT = 3'b011,
        OP_RET      = 3'b100
    } op_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// rtl/fetch_sequencer_return_stack.sv - return-address stack with full/empty flags
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0] sp_q, sp_d;
    logic [SP_W-1:0] top_idx;
    logic [W-1:0]    mem_q [DEPTH];

    assign top_idx  = sp_q - SP_W'(1);
    assign top_data = mem_q[top_idx[IDX_W-1:0]];
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);

    // The caller gates push on full and pop on empty; they are never both set.
    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push && !full) begin
            mem_q[sp_q[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program-counter sequencer with branch, jump table, call/return and halt
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          PC_W      = 8,
    parameter int          OFFSET_W  = 3,
    parameter int          SHIFT     = 2,
    parameter int          LUT_DEPTH = 8,
    parameter int          RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = DEFAULT_RESET_PC
) (
    input  logic                         CLK,
    input  logic                         Init_n,
    input  logic [2:0]                   Op,
    input  logic [OFFSET_W-1:0]          Target,
    input  logic [$clog2(LUT_DEPTH)-1:0] Lut_idx,
    input  logic                         Stall,
    input  logic                         Halt,
    input  logic                         Lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] Lut_waddr,
    input  logic [PC_W-1:0]              Lut_wdata,
    output logic [PC_W-1:0]              PC,
    output logic                         Done,
    output logic                         Fault
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] lut_rd;
    logic            ras_push, ras_pop, ras_full, ras_empty;
    logic [PC_W-1:0] ras_top;

    assign pc_inc = pc_q + PC_W'(1);
    assign br_off = PC_W'($signed(Target)) << SHIFT;
    assign lut_rd = lut_q[Lut_idx];

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (CLK),
        .resetn    (Init_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fault_d  = fault_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (state_q == ST_RUN) begin
            if (Halt) begin
                state_d = ST_HALTED;
            end else if (!Stall) begin
                case (op_e'(Op))
                    OP_BR_REL:  pc_d = pc_q + br_off;
                    OP_JMP_LUT: pc_d = lut_rd;
                    OP_CALL_LUT: begin
                        // A call on a full stack still jumps; only the return address is lost.
                        pc_d = lut_rd;
                        if (ras_full) fault_d  = 1'b1;
                        else          ras_push = 1'b1;
                    end
                    OP_RET: begin
                        if (ras_empty) begin
                            pc_d    = pc_inc;
                            fault_d = 1'b1;
                        end else begin
                            pc_d    = ras_top;
                            ras_pop = 1'b1;
                        end
                    end
                    default:    pc_d = pc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Init_n) begin
            state_q <= ST_RUN;
            pc_q    <= PC_W'(RESET_PC);
            fault_q <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            if (Lut_we) begin
                lut_q[Lut_waddr] <= Lut_wdata;
            end
        end
    end

    assign PC    = pc_q;
    assign Done  = (state_q == ST_HALTED);
    assign Fault = fault_q;

endmodule
